// File: rtl/host_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : host_run_sequencer
// Purpose  : Initiator side of the processor start/ack run handshake. A rising
//            edge of go in IDLE latches the program select and raises start
//            for START_HOLD cycles. When start falls the processor is launched.
//            The sequencer then counts RUN cycles until ack arrives or the
//            timeout expires. It reports done, the elapsed count and the
//            timeout status.
// Ports    : clk         - system clock, rising edge
//            reset       - asynchronous active-high reset
//            go          - run request (level); launch on 0->1 seen in IDLE
//            prog_sel_in - program select, sampled on the launch cycle
//            ack         - processor completion, sampled each RUN cycle
//            start       - registered start to the processor
//            prog_sel    - latched program select
//            busy        - high whenever not IDLE
//            done        - one-cycle pulse when a run ends
//            timeout     - last run ended by timeout (cleared on launch)
//            cycles      - RUN-cycle count of the last completed run
//            run_count   - completed runs, wraps at 8 bits
// Revision : 1.0 - initial release
// ============================================================================
module host_run_sequencer #(
  parameter int START_HOLD     = 4,
  parameter int TIMEOUT_CYCLES = 4200,
  parameter int CNT_W          = 16,
  parameter int SEL_W          = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [SEL_W-1:0] prog_sel_in,
  input  logic             ack,
  output logic             start,
  output logic [SEL_W-1:0] prog_sel,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles,
  output logic [7:0]       run_count
);

  // The hold counter only needs to reach START_HOLD-1.
  localparam int HOLD_W = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(START_HOLD - 1);
  localparam logic [CNT_W-1:0]  C_TIMEOUT   = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_go_q;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_start;
  logic [SEL_W-1:0]  r_prog_sel;
  logic              r_done;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_cycles;
  logic [7:0]        r_run_count;

  logic              w_go_rise;
  logic [CNT_W-1:0]  w_cnt_inc;

  assign w_go_rise = go & ~r_go_q;
  // Count including the current RUN cycle; this is the value reported when
  // the run ends on this cycle.
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_go_q      <= 1'b0;   // go already high at release counts as an edge
      r_hold_cnt  <= '0;
      r_cnt       <= '0;
      r_start     <= 1'b0;
      r_prog_sel  <= '0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_cycles    <= '0;
      r_run_count <= 8'd0;
    end else begin
      // go_q tracks go in every state so that edges outside IDLE are consumed
      // and a go held high across FINISH cannot relaunch.
      r_go_q <= go;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_start <= 1'b0;
          if (w_go_rise) begin
            r_state    <= S_HOLD;
            r_start    <= 1'b1;
            r_prog_sel <= prog_sel_in;
            r_timeout  <= 1'b0;
            r_hold_cnt <= '0;
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == C_HOLD_LAST) begin
            r_state <= S_RUN;
            r_start <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        S_RUN: begin
          // ack has priority over a timeout landing on the same cycle.
          if (ack) begin
            r_cycles <= w_cnt_inc;
            r_done   <= 1'b1;
            r_state  <= S_FINISH;
          end else if (w_cnt_inc == C_TIMEOUT) begin
            r_cycles  <= C_TIMEOUT;
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= S_FINISH;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_FINISH: begin
          r_run_count <= r_run_count + 8'd1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign start     = r_start;
  assign prog_sel  = r_prog_sel;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign cycles    = r_cycles;
  assign run_count = r_run_count;

endmodule
`default_nettype wire

// File: tb/tb_host_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_host_run_sequencer
// Purpose  : Self-checking bench for host_run_sequencer. Each run is described
//            as a transaction: program select, the RUN cycle on which ack
//            arrives, whether go is left high afterwards and an optional
//            reset point. Expected outputs follow from the handshake
//            latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_host_run_sequencer;

  localparam int START_HOLD     = 4;
  localparam int TIMEOUT_CYCLES = 12;
  localparam int CNT_W          = 16;
  localparam int SEL_W          = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             go;
  logic [SEL_W-1:0] prog_sel_in;
  logic             ack;
  logic             start;
  logic [SEL_W-1:0] prog_sel;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycles;
  logic [7:0]       run_count;

  int checks = 0;
  int errors = 0;

  // Reference state persisting between runs.
  int exp_sel;
  int exp_cycles;
  int exp_timeout;
  int exp_runs;

  host_run_sequencer #(
    .START_HOLD     (START_HOLD),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W),
    .SEL_W          (SEL_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .prog_sel_in (prog_sel_in),
    .ack         (ack),
    .start       (start),
    .prog_sel    (prog_sel),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .cycles      (cycles),
    .run_count   (run_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string ph, input bit e_start, input bit e_busy, input bit e_done);
    check_eq({ph, ".start"},     32'(start),     32'(e_start));
    check_eq({ph, ".busy"},      32'(busy),      32'(e_busy));
    check_eq({ph, ".done"},      32'(done),      32'(e_done));
    check_eq({ph, ".prog_sel"},  32'(prog_sel),  exp_sel);
    check_eq({ph, ".timeout"},   32'(timeout),   exp_timeout);
    check_eq({ph, ".cycles"},    32'(cycles),    exp_cycles);
    check_eq({ph, ".run_count"}, 32'(run_count), exp_runs);
  endtask

  task automatic model_reset();
    exp_sel     = 0;
    exp_cycles  = 0;
    exp_timeout = 0;
    exp_runs    = 0;
  endtask

  // One launch. k = RUN cycle on which ack arrives (k > TIMEOUT_CYCLES means
  // never). rst_j > 0 asserts reset asynchronously after rst_j RUN cycles.
  task automatic run_one(input int sel, input int k, input bit hold_go, input int rst_j);
    int run_end;
    int end_edge;
    int j;
    run_end  = (k < TIMEOUT_CYCLES) ? k : TIMEOUT_CYCLES;
    // Edge 1 launches, edges 1..START_HOLD show start, RUN cycle j is
    // evaluated on edge START_HOLD+1+j, done is visible after the last one.
    end_edge = START_HOLD + 1 + run_end;
    go          = 1'b1;
    prog_sel_in = SEL_W'(sel);
    ack         = 1'($urandom);
    for (int n = 1; n <= end_edge + 1; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        exp_sel     = sel;
        exp_timeout = 0;
      end
      if (n == end_edge) begin
        exp_cycles  = run_end;
        exp_timeout = (k > TIMEOUT_CYCLES) ? 1 : 0;
      end
      if (n == end_edge + 1) exp_runs = (exp_runs + 1) % 256;
      check_outputs("run", n <= START_HOLD, n <= end_edge, n == end_edge);
      if (rst_j > 0 && n == START_HOLD + 1 + rst_j) begin
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("rst_async", 1'b0, 1'b0, 1'b0);
        go  = 1'b1;   // held through release: must count as a fresh edge
        ack = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("rst_held", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        return;
      end
      // Drive inputs for edge n+1.
      j = n - START_HOLD;
      if (j >= 1 && j <= run_end) ack = (j == k);
      else                        ack = 1'($urandom);
      if (n + 1 <= end_edge) go = 1'($urandom);
      else                   go = hold_go;
      prog_sel_in = SEL_W'($urandom);
    end
    // IDLE tail: ack noise is ignored and a go still high must not relaunch.
    repeat (3) begin
      @(posedge clk);
      #1;
      check_outputs("idle", 1'b0, 1'b0, 1'b0);
      ack         = 1'($urandom);
      prog_sel_in = SEL_W'($urandom);
    end
    go = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("idle_go0", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset       = 1'b1;
    go          = 1'b0;
    ack         = 1'b0;
    prog_sel_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    run_one(2, 10, 1'b0, 0);                    // ack on 10th RUN cycle
    run_one(1, 100, 1'b0, 0);                   // timeout
    run_one(3, 4, 1'b1, 0);                     // clears timeout; go held after
    run_one(0, TIMEOUT_CYCLES, 1'b1, 0);        // ack on the timeout cycle
    run_one(1, 1, 1'b0, 0);                     // ack on first RUN cycle
    run_one(2, 20, 1'b0, 5);                    // reset mid-RUN at cnt=5
    run_one(3, 7, 1'b0, 0);                     // launch after reset

    // Random runs; enough of them to wrap run_count past 255.
    for (int r = 0; r < 262; r++) begin
      run_one(int'($urandom_range(0, (1 << SEL_W) - 1)),
              int'($urandom_range(1, TIMEOUT_CYCLES + 3)),
              1'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
